melody_tone_sequencer: RTL

//   Plays a fixed 8-note melody (C4 D4 E4 F4 G4 A4 B4 C5) on the board buzzer. A note ROM

---
 rtl/melody_tone_sequencer_if.sv | 28 ++
 rtl/melody_tone_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/melody_tone_sequencer_if.sv
// Control/status bundle between the push-button logic, the melody sequencer and the buzzer pin.
// The master drives start/stop pulses and observes tone and progress outputs.
interface melody_tone_sequencer_if;
    logic       start;
    logic       stop;
    logic       buzzer;
    logic       busy;
    logic [2:0] note_idx;
    logic       done;

    modport master (
        output start,
        output stop,
        input  buzzer,
        input  busy,
        input  note_idx,
        input  done
    );

    modport slave (
        input  start,
        input  stop,
        output buzzer,
        output busy,
        output note_idx,
        output done
    );
endinterface

// File: rtl/melody_tone_sequencer.sv
// Plays an 8-note scale on the buzzer: a note ROM sets a square-wave divider,
// and a duration timer steps through the notes with a silent gap after each one.
//
// state  | meaning
// IDLE   | silent, waiting for a start pulse
// PLAY   | current note sounding for beats*BEAT_CYCLES clks
// GAP    | articulation silence for GAP_CYCLES clks
// DONE   | one-clk completion pulse, then back to IDLE
module melody_tone_sequencer #(
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_250_000,
    parameter int DIV_SHIFT   = 0
) (
    input  logic                     clk_50MHz,
    input  logic                     reset,
    melody_tone_sequencer_if.slave   bus
);

    localparam int DUR_MAX = (2 * BEAT_CYCLES > GAP_CYCLES) ? 2 * BEAT_CYCLES : GAP_CYCLES;
    localparam int DUR_W   = $clog2(DUR_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [16:0]      r_tone;
    logic [DUR_W-1:0] r_dur;
    logic [2:0]       r_note_idx;
    logic             r_buzzer;
    logic             r_busy;
    logic             r_done;

    logic [16:0]      w_rom_n;
    logic [1:0]       w_rom_beats;
    logic [16:0]      w_tone_n;
    logic [DUR_W-1:0] w_play_tc;
    logic [DUR_W-1:0] w_gap_tc;

    always_comb begin
        w_rom_n     = 17'd0;
        w_rom_beats = 2'd1;
        case (r_note_idx)
            3'd0: begin w_rom_n = 17'd95554; w_rom_beats = 2'd1; end
            3'd1: begin w_rom_n = 17'd85131; w_rom_beats = 2'd1; end
            3'd2: begin w_rom_n = 17'd75841; w_rom_beats = 2'd1; end
            3'd3: begin w_rom_n = 17'd71585; w_rom_beats = 2'd1; end
            3'd4: begin w_rom_n = 17'd63775; w_rom_beats = 2'd1; end
            3'd5: begin w_rom_n = 17'd56817; w_rom_beats = 2'd1; end
            3'd6: begin w_rom_n = 17'd50619; w_rom_beats = 2'd1; end
            3'd7: begin w_rom_n = 17'd47777; w_rom_beats = 2'd2; end
            default: begin w_rom_n = 17'd0; w_rom_beats = 2'd1; end
        endcase
    end

    assign w_tone_n  = w_rom_n >> DIV_SHIFT;
    assign w_play_tc = (w_rom_beats == 2'd2) ? DUR_W'(2 * BEAT_CYCLES - 1) : DUR_W'(BEAT_CYCLES - 1);
    assign w_gap_tc  = DUR_W'(GAP_CYCLES - 1);

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tone     <= 17'd0;
            r_dur      <= '0;
            r_note_idx <= 3'd0;
            r_buzzer   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // stop outranks everything, including a simultaneous start
            if (bus.stop) begin
                r_state    <= S_IDLE;
                r_tone     <= 17'd0;
                r_dur      <= '0;
                r_note_idx <= 3'd0;
                r_buzzer   <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_state    <= S_PLAY;
                            r_busy     <= 1'b1;
                            r_note_idx <= 3'd0;
                            r_tone     <= 17'd0;
                            r_dur      <= '0;
                            r_buzzer   <= 1'b0;
                        end
                    end
                    S_PLAY: begin
                        if (r_dur == w_play_tc) begin
                            r_state  <= S_GAP;
                            r_dur    <= '0;
                            r_tone   <= 17'd0;
                            r_buzzer <= 1'b0;
                        end else begin
                            r_dur <= r_dur + DUR_W'(1);
                            if (w_tone_n == 17'd0) begin
                                r_tone   <= 17'd0;
                                r_buzzer <= 1'b0;
                            end else if (r_tone == w_tone_n) begin
                                r_tone   <= 17'd0;
                                r_buzzer <= ~r_buzzer;
                            end else begin
                                r_tone <= r_tone + 17'd1;
                            end
                        end
                    end
                    S_GAP: begin
                        r_buzzer <= 1'b0;
                        r_tone   <= 17'd0;
                        if (r_dur == w_gap_tc) begin
                            r_dur <= '0;
                            if (r_note_idx == 3'd7) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state    <= S_PLAY;
                                r_note_idx <= r_note_idx + 3'd1;
                            end
                        end else begin
                            r_dur <= r_dur + DUR_W'(1);
                        end
                    end
                    S_DONE: begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_note_idx <= 3'd0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.buzzer   = r_buzzer;
    assign bus.busy     = r_busy;
    assign bus.note_idx = r_note_idx;
    assign bus.done     = r_done;

endmodule
